// File: rtl/vedic_mult4_seq.sv
// vedic_mult4_seq: sequential 4x4 Urdhva Tiryagbhyam multiplier, one product column per cycle
module vedic_mult4_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t     state_q, state_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    logic [7:0] p_q, p_d;
    logic [2:0] carry_q, carry_d, col_q, col_d, col_sum;
    logic [3:0] s;
    logic [3:0] pp [4];
    // partial products come from a NOR-of-inverted-inputs AND stage
    for (genvar i = 0; i < 4; i++) begin : g_pp
        assign pp[i] = ~(~{4{a_q[i]}} | ~b_q);
    end
    always_comb begin
        col_sum = 3'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                col_sum = (3'(r + c) == col_q) ? col_sum + {2'b00, pp[r][c]} : col_sum;
        s = {1'b0, carry_q} + {1'b0, col_sum};
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        carry_d = carry_q;
        col_d   = col_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                p_d     = 8'h00;
                carry_d = 3'd0;
                col_d   = 3'd0;
                state_d = CALC;
            end
            CALC: begin
                p_d[col_q] = s[0];
                carry_d    = s[3:1];
                col_d      = (col_q == 3'd6) ? 3'd0 : col_q + 3'd1;
                if (col_q == 3'd6) begin
                    p_d[7]  = s[1];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            p_q     <= 8'h00;
            carry_q <= 3'd0;
            col_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            carry_q <= carry_d;
            col_q   <= col_d;
        end
    end
    assign p    = p_q;
    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_vedic_mult4_seq.sv
// tb_vedic_mult4_seq: directed and randomized checks of the sequential multiplier against a*b
`timescale 1ns/1ps
module tb_vedic_mult4_seq;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] a, b;
    logic [7:0] p;
    logic       busy, done;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         done_cnt = 0;

    vedic_mult4_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .p(p), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the done pulse.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tbv, input int poke);
        logic [7:0] exp;
        int bc;
        exp = 8'(ta * tbv);
        a = ta;
        b = tbv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) break;
            if (busy) bc++;
            if (k == 0) begin
                a = 4'($urandom);
                b = 4'($urandom);
            end
            if (k == poke) begin
                start = 1'b1;
                a = ~ta;
                b = ~tbv;
            end else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("product", {24'd0, p}, {24'd0, exp});
        check("busy_cycles", bc, 32'd7);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("p_hold", {24'd0, p}, {24'd0, exp});
    endtask

    initial begin
        int d0;
        time t_prev;
        logic [3:0] ra, rb;
        logic [7:0] rexp;
        rst = 1'b1;
        start = 1'b0;
        a = 4'h0;
        b = 4'h0;
        #2;
        check("reset_p", {24'd0, p}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        do_op(4'hF, 4'hF, -1);
        check("ff_const", {24'd0, p}, 32'hE1);
        do_op(4'h9, 4'h7, -1);
        check("97_const", {24'd0, p}, 32'h3F);
        do_op(4'h0, 4'hB, -1);
        check("0b_const", {24'd0, p}, 32'h00);

        // start re-pulsed in the third CALC cycle must be ignored
        d0 = done_cnt;
        do_op(4'hD, 4'h6, 2);
        check("ignored_start_done_cnt", done_cnt - d0, 32'd1);
        @(negedge clk);
        check("no_restart", {31'd0, busy}, 32'd0);

        // start tied high: back-to-back ops with a 9-cycle period
        start = 1'b1;
        t_prev = 0;
        for (int op = 0; op < 4; op++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rexp = 8'(ra * rb);
            a = ra;
            b = rb;
            @(negedge clk);
            a = ~ra;
            b = 4'($urandom);
            for (int k = 0; k < 20; k++) begin
                if (done) break;
                @(negedge clk);
            end
            check("b2b_done", {31'd0, done}, 32'd1);
            check("b2b_product", {24'd0, p}, {24'd0, rexp});
            if (op > 0) check("b2b_period", 32'($time - t_prev), 32'd90);
            t_prev = $time;
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // asynchronous reset in the middle of CALC (col=4)
        a = 4'hF;
        b = 4'hF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        d0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        check("async_rst_p", {24'd0, p}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_op(4'h9, 4'h7, -1);
        check("abort_done_cnt", done_cnt - d0, 32'd1);

        // exhaustive sweep
        d0 = done_cnt;
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                do_op(4'(ia), 4'(ib), -1);
        check("sweep_done_cnt", done_cnt - d0, 32'd256);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/vedic_mult4_seq.md
VEDIC_MULT4_SEQ -- requirements
Module: vedic_mult4_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits and product width at 8 bits.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to multiply; sampled only in IDLE.
REQ-005 a  input  4  multiplicand; captured on the start-accept edge.
REQ-006 b  input  4  multiplier; captured on the start-accept edge.
REQ-007 p  output  8  product register.
REQ-008 busy  output  1  high while a multiplication is in progress.
REQ-009 done  output  1  one-cycle pulse marking p valid.

Function
REQ-010 The block SHALL compute p = a*b unsigned, Urdhva Tiryagbhyam style: one output column per cycle, columns 0..6.
- Column k is the sum of a[i]&b[j] over all i+j=k.
- Each partial-product bit SHALL be formed as the NOR of inverted operand bits, the existing NOR-based AND stage this block consumes.
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-012 IDLE with start=1 at an edge SHALL:
- latch a and b into internal registers;
- clear p, the carry register and the column counter col;
- enter CALC.
REQ-013 IDLE with start=0 SHALL hold all registers unchanged.
REQ-014 Each CALC edge SHALL:
- form s = carry + (column col sum), s being 4 bits wide;
- write p[col] = s[0];
- set carry = s[3:1] (3 bits);
- increment col.
REQ-015 The CALC edge with col=6 SHALL additionally write p[7] = carry-out bit 0 and enter DONE; carry-out bits above bit 0 are zero by construction and SHALL be ignored.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 Timing:
- busy SHALL be 1 in CALC and 0 otherwise.
- done SHALL be 1 in DONE and 0 otherwise.
- Both SHALL be decoded from registered state, with no combinational path from start.
REQ-018 Latency: start accepted at edge N; done is high during the cycle after edge N+7; p is final from edge N+7 onward.
REQ-019 p SHALL hold its value after DONE until the next start-accept edge clears it.
REQ-020 start in CALC or DONE SHALL be ignored, with no restart and no queuing. Changes on a or b after the accept edge SHALL NOT affect the result.
REQ-021 start held continuously high SHALL give back-to-back operations with one IDLE cycle between them. The period is 9 cycles, and each operation re-samples a and b.
REQ-022 col SHALL be 3 bits wide and SHALL never exceed 6. Column sums SHALL never overflow the 4-bit s: maximum is 4 terms plus carry ≤3.

Reset
REQ-023 rst=1 SHALL immediately force, without waiting for clk:
- state=IDLE;
- p=8'h00, busy=0, done=0;
- col=0, carry=0, operand registers=0.
REQ-024 Reset asserted during CALC or DONE SHALL abort the operation. No done pulse SHALL follow. The block SHALL accept start on the first edge after rst deasserts.

Verification
REQ-025 Directed scenarios the bench SHALL cover:
- a=4'hF, b=4'hF, start pulse → busy high for 7 cycles, then done pulse with p=8'hE1 (225).
- a=4'h9, b=4'h7 → p=8'h3F; a=4'h0, b=4'hB → p=8'h00 with a normal 7-cycle busy and a done pulse.
- start pulsed again in CALC cycle 3 with different a and b → ignored; first result correct; exactly one done pulse.
- start tied high with a and b changed each op → results every 9 cycles, each matching the operands sampled at its accept edge.
- rst asserted asynchronously mid-CALC (col=4) → p=0, busy=0, done=0 before the next clk edge; no done pulse; next op correct.
- Exhaustive sweep of all 256 a,b pairs against a reference product → zero mismatches; done count = 256.
